id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 133 +++++++++++++
 tb/tb_id_ex_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
// Flush inserts a bubble, stall holds the register, and rst overrides both asynchronously.
module id_ex_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_dst,
    input  logic [3:0]  id_aluctr,
    input  logic        id_alusrc,
    input  logic        id_shiftsrc,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_dst,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_dst,
    input  logic [31:0] memwb_result,
    output logic [31:0] ex_A,
    output logic [31:0] ex_B,
    output logic [3:0]  ex_aluctr,
    output logic [31:0] ex_store_data,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_dst,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        load_use
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] imm_q;
    logic [4:0]  shamt_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [4:0]  dst_q;
    logic [3:0]  aluctr_q;
    logic        alusrc_q;
    logic        shiftsrc_q;
    logic        regwrite_q;
    logic        memread_q;
    logic        memwrite_q;

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            valid_q    <= 1'b0;
            pc_q       <= RESET_PC;
            rs_data_q  <= 32'd0;
            rt_data_q  <= 32'd0;
            imm_q      <= 32'd0;
            shamt_q    <= 5'd0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            dst_q      <= 5'd0;
            aluctr_q   <= 4'd0;
            alusrc_q   <= 1'b0;
            shiftsrc_q <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else if (!stall) begin
            valid_q    <= id_valid;
            pc_q       <= id_pc;
            rs_data_q  <= id_rs_data;
            rt_data_q  <= id_rt_data;
            imm_q      <= id_imm;
            shamt_q    <= id_shamt;
            rs_q       <= id_rs;
            rt_q       <= id_rt;
            dst_q      <= id_dst;
            aluctr_q   <= id_aluctr;
            alusrc_q   <= id_alusrc;
            shiftsrc_q <= id_shiftsrc;
            regwrite_q <= id_regwrite;
            memread_q  <= id_memread;
            memwrite_q <= id_memwrite;
        end
    end

    // EX/MEM is the younger producer, so it takes priority; $0 is never forwarded.
    always_comb begin
        fwd_a = rs_data_q;
        if (exmem_regwrite && exmem_dst == rs_q && rs_q != 5'd0) begin
            fwd_a = exmem_result;
        end else if (memwb_regwrite && memwb_dst == rs_q && rs_q != 5'd0) begin
            fwd_a = memwb_result;
        end

        fwd_b = rt_data_q;
        if (exmem_regwrite && exmem_dst == rt_q && rt_q != 5'd0) begin
            fwd_b = exmem_result;
        end else if (memwb_regwrite && memwb_dst == rt_q && rt_q != 5'd0) begin
            fwd_b = memwb_result;
        end
    end

    always_comb begin
        ex_A          = shiftsrc_q ? {27'd0, shamt_q} : fwd_a;
        ex_B          = alusrc_q ? imm_q : fwd_b;
        ex_store_data = fwd_b;
        ex_aluctr     = aluctr_q;
        ex_pc         = pc_q;
        ex_dst        = dst_q;
        ex_valid      = valid_q;
        ex_regwrite   = regwrite_q & valid_q;
        ex_memread    = memread_q & valid_q;
        ex_memwrite   = memwrite_q & valid_q;
        load_use      = valid_q && memread_q && (dst_q != 5'd0) && id_valid &&
                        ((id_use_rs && id_rs == dst_q) || (id_use_rt && id_rt == dst_q));
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: capture, forwarding, immediates,
// load-use, stall/flush and asynchronous reset.
module tb_id_ex_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic        id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_dst;
    logic [3:0]  id_aluctr;
    logic        id_alusrc, id_shiftsrc, id_regwrite, id_memread, id_memwrite;
    logic        id_use_rs, id_use_rt;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_dst, memwb_dst;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] ex_A, ex_B, ex_store_data, ex_pc;
    logic [3:0]  ex_aluctr;
    logic [4:0]  ex_dst;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_aluctr(id_aluctr),
        .id_alusrc(id_alusrc), .id_shiftsrc(id_shiftsrc), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .exmem_regwrite(exmem_regwrite), .exmem_dst(exmem_dst),
        .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite),
        .memwb_dst(memwb_dst), .memwb_result(memwb_result),
        .ex_A(ex_A), .ex_B(ex_B), .ex_aluctr(ex_aluctr), .ex_store_data(ex_store_data),
        .ex_pc(ex_pc), .ex_dst(ex_dst), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .load_use(load_use)
    );

    task automatic clear_inputs();
        stall = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs_data = 0; id_rt_data = 0;
        id_imm = 0; id_shamt = 0; id_rs = 0; id_rt = 0; id_dst = 0; id_aluctr = 0;
        id_alusrc = 0; id_shiftsrc = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
        id_use_rs = 0; id_use_rt = 0; exmem_regwrite = 0; exmem_dst = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_dst = 0; memwb_result = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ex_valid); end
        n_checks++; if (ex_pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h want %h", ex_pc, RST_PC); end
        n_checks++; if (ex_A !== 32'd0 || ex_B !== 32'd0 || ex_store_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_data got A=%h B=%h S=%h want 0", ex_A, ex_B, ex_store_data); end
        n_checks++; if ({ex_regwrite, ex_memread, ex_memwrite, ex_dst, ex_aluctr, load_use} !== 13'd0) begin
            n_fail++; $display("FAIL reset_ctrl got rw=%b mr=%b mw=%b dst=%0d alu=%h lu=%b want 0",
                                ex_regwrite, ex_memread, ex_memwrite, ex_dst, ex_aluctr, load_use); end
        @(negedge clk);
        rst = 0;
    endtask

    // ADDU $3,$1,$2 with rs=5, rt=7; then forwarding checks while stalled.
    task automatic test_addu_forwarding();
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_pc = 32'h100; id_rs = 1; id_rt = 2; id_dst = 3;
        id_rs_data = 5; id_rt_data = 7; id_aluctr = 4'b0000; id_regwrite = 1;
        id_use_rs = 1; id_use_rt = 1;
        tick();
        n_checks++; if (ex_A !== 32'd5) begin n_fail++; $display("FAIL addu_A got %h want 5", ex_A); end
        n_checks++; if (ex_B !== 32'd7) begin n_fail++; $display("FAIL addu_B got %h want 7", ex_B); end
        n_checks++; if (ex_aluctr !== 4'b0000 || ex_regwrite !== 1'b1 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL addu_ctrl got alu=%h rw=%b v=%b want 0/1/1", ex_aluctr, ex_regwrite, ex_valid); end
        n_checks++; if (ex_dst !== 5'd3 || ex_pc !== 32'h100) begin
            n_fail++; $display("FAIL addu_dst_pc got %0d/%h want 3/100", ex_dst, ex_pc); end
        @(negedge clk);
        stall = 1; id_rs_data = 32'hdead;
        exmem_regwrite = 1; exmem_dst = 1; exmem_result = 100;
        memwb_regwrite = 1; memwb_dst = 1; memwb_result = 200;
        #1;
        n_checks++; if (ex_A !== 32'd100) begin n_fail++; $display("FAIL fwd_exmem_wins got %0d want 100", ex_A); end
        tick();
        exmem_regwrite = 0;
        #1;
        n_checks++; if (ex_A !== 32'd200) begin n_fail++; $display("FAIL fwd_memwb got %0d want 200", ex_A); end
        memwb_dst = 2;
        #1;
        n_checks++; if (ex_A !== 32'd5 || ex_B !== 32'd200 || ex_store_data !== 32'd200) begin
            n_fail++; $display("FAIL fwd_rt got A=%0d B=%0d S=%0d want 5/200/200", ex_A, ex_B, ex_store_data); end
        memwb_regwrite = 0;
        exmem_regwrite = 1; exmem_dst = 3; exmem_result = 55;
        #1;
        n_checks++; if (ex_A !== 32'd5 || ex_B !== 32'd7) begin
            n_fail++; $display("FAIL fwd_nomatch got A=%0d B=%0d want 5/7", ex_A, ex_B); end
        @(negedge clk);
        stall = 0;
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_rs = 0; id_rt = 0; id_rs_data = 32'h55; id_rt_data = 32'h66;
        exmem_regwrite = 1; exmem_dst = 0; exmem_result = 99;
        memwb_regwrite = 1; memwb_dst = 0; memwb_result = 98;
        tick();
        n_checks++; if (ex_A !== 32'h55 || ex_B !== 32'h66) begin
            n_fail++; $display("FAIL zero_reg got A=%h B=%h want 55/66", ex_A, ex_B); end
    endtask

    task automatic test_shift_imm();
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_aluctr = 4'b1000; id_shiftsrc = 1; id_shamt = 4;
        id_rs = 0; id_rs_data = 32'h77; id_rt = 2; id_rt_data = 1; id_dst = 4; id_regwrite = 1;
        tick();
        n_checks++; if (ex_A !== 32'd4 || ex_B !== 32'd1) begin
            n_fail++; $display("FAIL sll got A=%h B=%h want 4/1", ex_A, ex_B); end
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_aluctr = 4'b0100; id_alusrc = 1; id_imm = 32'h0000_FFFF;
        id_rs = 1; id_rs_data = 32'h10; id_rt = 5; id_rt_data = 32'h1234;
        tick();
        n_checks++; if (ex_B !== 32'h0000_FFFF || ex_store_data !== 32'h1234) begin
            n_fail++; $display("FAIL ori got B=%h S=%h want 0000ffff/1234", ex_B, ex_store_data); end
        exmem_regwrite = 1; exmem_dst = 5; exmem_result = 32'hABCD;
        #1;
        n_checks++; if (ex_B !== 32'h0000_FFFF || ex_store_data !== 32'hABCD) begin
            n_fail++; $display("FAIL ori_fwd_store got B=%h S=%h want 0000ffff/abcd", ex_B, ex_store_data); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_pc = 32'h200; id_memread = 1; id_regwrite = 1; id_dst = 8; id_rs = 29;
        tick();
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_use_rt = 1; id_rt = 8; id_pc = 32'h204;
        #1;
        n_checks++; if (load_use !== 1'b1) begin n_fail++; $display("FAIL load_use_hit got %b want 1", load_use); end
        id_valid = 0;
        #1;
        n_checks++; if (load_use !== 1'b0) begin n_fail++; $display("FAIL load_use_idinvalid got %b want 0", load_use); end
        id_valid = 1; id_use_rt = 0; id_use_rs = 1; id_rs = 8;
        #1;
        n_checks++; if (load_use !== 1'b1) begin n_fail++; $display("FAIL load_use_rs got %b want 1", load_use); end
        id_use_rs = 0;
        #1;
        n_checks++; if (load_use !== 1'b0) begin n_fail++; $display("FAIL load_use_nouse got %b want 0", load_use); end
        stall = 1;
        tick();
        n_checks++; if (ex_dst !== 5'd8 || ex_memread !== 1'b1 || ex_pc !== 32'h200 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_hold got dst=%0d mr=%b pc=%h v=%b want 8/1/200/1",
                               ex_dst, ex_memread, ex_pc, ex_valid); end
        @(negedge clk);
        flush = 1; stall = 1;
        tick();
        n_checks++; if (ex_valid !== 1'b0 || ex_pc !== RST_PC || ex_dst !== 5'd0 || ex_memread !== 1'b0) begin
            n_fail++; $display("FAIL flush_bubble got v=%b pc=%h dst=%0d mr=%b want 0/%h/0/0",
                               ex_valid, ex_pc, ex_dst, ex_memread, RST_PC); end
        @(negedge clk);
        clear_inputs();
        id_valid = 0; id_regwrite = 1; id_memwrite = 1; id_dst = 9;
        tick();
        n_checks++; if (ex_regwrite !== 1'b0 || ex_memwrite !== 1'b0 || ex_dst !== 5'd9) begin
            n_fail++; $display("FAIL valid_gate got rw=%b mw=%b dst=%0d want 0/0/9", ex_regwrite, ex_memwrite, ex_dst); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_pc = 32'h300; id_rs = 1; id_rs_data = 32'h11; id_dst = 6; id_regwrite = 1;
        tick();
        @(negedge clk);
        stall = 1;
        #1;
        rst = 1;
        #1;
        n_checks++; if (ex_valid !== 1'b0 || ex_pc !== RST_PC || ex_A !== 32'd0 || ex_regwrite !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got v=%b pc=%h A=%h rw=%b want 0/%h/0/0",
                               ex_valid, ex_pc, ex_A, ex_regwrite, RST_PC); end
        tick();
        @(negedge clk);
        rst = 0; stall = 0; id_pc = 32'h400;
        tick();
        n_checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h400 || ex_A !== 32'h11) begin
            n_fail++; $display("FAIL post_reset_capture got v=%b pc=%h A=%h want 1/400/11", ex_valid, ex_pc, ex_A); end
    endtask

    initial begin
        test_reset();
        test_addu_forwarding();
        test_zero_reg();
        test_shift_imm();
        test_load_use();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
